// File: rtl/dispatch_alu_buffer.sv
// 2-wide in-order skid FIFO between rename/dispatch and the ALU issue queue.
// Buffered uops snoop the writeback wakeup bus so no producer wakeup is missed.

package dispatch_alu_buffer_pkg;
  localparam int unsigned PREG_W = 6;

  typedef struct packed {
    logic prs1_rdy;
    logic prs2_rdy;
  } alu_rdys_t;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [PREG_W-1:0] pdest;
    logic [PREG_W-1:0] op0PAddr;
    logic [PREG_W-1:0] op1PAddr;
  } alu_ops_t;

  typedef struct packed {
    alu_rdys_t rdys;
    alu_ops_t  ops;
  } ALU_Queue_Meta;

  typedef struct packed {
    logic              wen_0;
    logic              wen_1;
    logic              wen_2;
    logic              wen_3;
    logic [PREG_W-1:0] wb_num0_i;
    logic [PREG_W-1:0] wb_num1_i;
    logic [PREG_W-1:0] wb_num2_i;
    logic [PREG_W-1:0] wb_num3_i;
  } Wake_Info;
endpackage

module dispatch_alu_buffer
  import dispatch_alu_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  Wake_Info      wake_Info,
  input  logic          in_valid_0,
  input  logic          in_valid_1,
  input  ALU_Queue_Meta in_uop_0,
  input  ALU_Queue_Meta in_uop_1,
  output logic          in_ready,
  input  logic          iq_ready,
  output logic          enq_req_0,
  output logic          enq_req_1,
  output ALU_Queue_Meta inst_Ops_0,
  output ALU_Queue_Meta inst_Ops_1
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DepthCnt  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PushLimit = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] TwoCnt    = CNT_W'(2);

  function automatic logic wb_hit(input Wake_Info w, input logic [PREG_W-1:0] preg);
    return (w.wen_0 && (w.wb_num0_i == preg)) || (w.wen_1 && (w.wb_num1_i == preg)) ||
           (w.wen_2 && (w.wb_num2_i == preg)) || (w.wen_3 && (w.wb_num3_i == preg));
  endfunction

  function automatic ALU_Queue_Meta apply_wake(input ALU_Queue_Meta u, input Wake_Info w);
    ALU_Queue_Meta r;
    r = u;
    r.rdys.prs1_rdy = u.rdys.prs1_rdy | wb_hit(w, u.ops.op0PAddr);
    r.rdys.prs2_rdy = u.rdys.prs2_rdy | wb_hit(w, u.ops.op1PAddr);
    return r;
  endfunction

  ALU_Queue_Meta    storage_q [DEPTH];
  ALU_Queue_Meta    storage_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             take_0, take_1;
  logic [1:0]       push_n, pop_n;
  ALU_Queue_Meta    first_uop;

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  // in_ready looks at the registered count only, so a same-cycle pop never frees room.
  assign in_ready  = (count_q <= PushLimit);
  assign enq_req_0 = iq_ready && (count_q != '0);
  assign enq_req_1 = iq_ready && (count_q >= TwoCnt);

  assign inst_Ops_0 = apply_wake(storage_q[head_q], wake_Info);
  assign inst_Ops_1 = apply_wake(storage_q[head_p1], wake_Info);

  assign take_0    = in_ready && !flush && in_valid_0;
  assign take_1    = in_ready && !flush && in_valid_1;
  assign push_n    = {1'b0, take_0} + {1'b0, take_1};
  assign pop_n     = {1'b0, enq_req_0} + {1'b0, enq_req_1};
  assign first_uop = in_valid_0 ? in_uop_0 : in_uop_1;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      storage_d[i] = apply_wake(storage_q[i], wake_Info);
    end
    if (push_n != 2'd0) begin
      storage_d[tail_q] = apply_wake(first_uop, wake_Info);
    end
    if (push_n == 2'd2) begin
      storage_d[tail_p1] = apply_wake(in_uop_1, wake_Info);
    end

    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= storage_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= DepthCnt);
      assert (CNT_W'(pop_n) <= count_q);
      assert (!enq_req_1 || enq_req_0);
    end
  end

endmodule

// File: tb/tb_dispatch_alu_buffer.sv
// Directed bench for dispatch_alu_buffer: a queue-based reference model checked every
// cycle, plus literal expectations for the hand-worked scenarios.

module tb_dispatch_alu_buffer;
  import dispatch_alu_buffer_pkg::*;

  localparam int DEPTH_TB = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  Wake_Info      wake_Info;
  logic          in_valid_0, in_valid_1;
  ALU_Queue_Meta in_uop_0, in_uop_1;
  logic          in_ready;
  logic          iq_ready;
  logic          enq_req_0, enq_req_1;
  ALU_Queue_Meta inst_Ops_0, inst_Ops_1;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  dispatch_alu_buffer #(.DEPTH(DEPTH_TB)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wake_Info  (wake_Info),
    .in_valid_0 (in_valid_0),
    .in_valid_1 (in_valid_1),
    .in_uop_0   (in_uop_0),
    .in_uop_1   (in_uop_1),
    .in_ready   (in_ready),
    .iq_ready   (iq_ready),
    .enq_req_0  (enq_req_0),
    .enq_req_1  (enq_req_1),
    .inst_Ops_0 (inst_Ops_0),
    .inst_Ops_1 (inst_Ops_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordinary queue holding the buffered uops oldest-first.
  ALU_Queue_Meta mq[$];
  int            n_pop;
  bit            room;

  function automatic ALU_Queue_Meta woken(input ALU_Queue_Meta u, input Wake_Info w);
    logic [3:0] en;
    logic [5:0] num [4];
    en     = {w.wen_3, w.wen_2, w.wen_1, w.wen_0};
    num[0] = w.wb_num0_i;
    num[1] = w.wb_num1_i;
    num[2] = w.wb_num2_i;
    num[3] = w.wb_num3_i;
    for (int k = 0; k < 4; k++) begin
      if (en[k] && num[k] == u.ops.op0PAddr) u.rdys.prs1_rdy = 1'b1;
      if (en[k] && num[k] == u.ops.op1PAddr) u.rdys.prs2_rdy = 1'b1;
    end
    return u;
  endfunction

  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
    end else begin
      room  = (DEPTH_TB - int'(mq.size())) >= 2;
      n_pop = iq_ready ? ((mq.size() >= 2) ? 2 : int'(mq.size())) : 0;
      repeat (n_pop) void'(mq.pop_front());
      foreach (mq[i]) mq[i] = woken(mq[i], wake_Info);
      if (room && in_valid_0) mq.push_back(woken(in_uop_0, wake_Info));
      if (room && in_valid_1) mq.push_back(woken(in_uop_1, wake_Info));
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      check("model in_ready", 64'(in_ready), 64'((DEPTH_TB - int'(mq.size())) >= 2));
      check("model enq_req_0", 64'(enq_req_0), 64'(iq_ready && mq.size() >= 1));
      check("model enq_req_1", 64'(enq_req_1), 64'(iq_ready && mq.size() >= 2));
      if (mq.size() >= 1) check("model inst_Ops_0", 64'(inst_Ops_0), 64'(woken(mq[0], wake_Info)));
      if (mq.size() >= 2) check("model inst_Ops_1", 64'(inst_Ops_1), 64'(woken(mq[1], wake_Info)));
    end
  end

  function automatic ALU_Queue_Meta mk(input logic [5:0] a0, input logic [5:0] a1);
    ALU_Queue_Meta u;
    u              = '0;
    u.ops.op0PAddr = a0;
    u.ops.op1PAddr = a1;
    u.ops.pdest    = a0 ^ 6'h2a;
    u.ops.opcode   = {2'b01, a1};
    return u;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v0, input logic v1, input ALU_Queue_Meta u0,
                       input ALU_Queue_Meta u1);
    in_valid_0 = v0;
    in_valid_1 = v1;
    in_uop_0   = u0;
    in_uop_1   = u1;
  endtask

  task automatic idle_in();
    in_valid_0 = 1'b0;
    in_valid_1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wake_Info = '0; iq_ready = 1'b0;
    in_valid_0 = 1'b0; in_valid_1 = 1'b0; in_uop_0 = '0; in_uop_1 = '0;
    step(); step();
    rst = 1'b0;
    started = 1'b1;

    // Reset state; empty buffer never requests even with iq_ready high.
    iq_ready = 1'b1; #1;
    check("reset enq_req_0", 64'(enq_req_0), 64'd0);
    check("reset enq_req_1", 64'(enq_req_1), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset inst_Ops_0", 64'(inst_Ops_0), 64'd0);
    check("reset inst_Ops_1", 64'(inst_Ops_1), 64'd0);
    iq_ready = 1'b0;

    // Push a pair while blocked, then release.
    offer(1, 1, mk(5, 6), mk(7, 8)); step(); idle_in();
    check("pair in_ready", 64'(in_ready), 64'd1);
    check("pair enq_req_0 blocked", 64'(enq_req_0), 64'd0);
    check("pair head op0", 64'(inst_Ops_0.ops.op0PAddr), 64'd5);
    check("pair head+1 op0", 64'(inst_Ops_1.ops.op0PAddr), 64'd7);
    iq_ready = 1'b1; #1;
    check("pair enq_req_0", 64'(enq_req_0), 64'd1);
    check("pair enq_req_1", 64'(enq_req_1), 64'd1);
    step();
    check("pair drained", 64'(enq_req_0), 64'd0);
    iq_ready = 1'b0;

    // Fill to DEPTH; a third pair must be refused.
    offer(1, 1, mk(10, 1), mk(11, 1)); step();
    offer(1, 1, mk(20, 1), mk(21, 1)); step();
    check("full in_ready", 64'(in_ready), 64'd0);
    offer(1, 1, mk(30, 1), mk(31, 1)); step(); idle_in();
    check("full still", 64'(in_ready), 64'd0);
    iq_ready = 1'b1; #1;
    check("drain A0", 64'(inst_Ops_0.ops.op0PAddr), 64'd10);
    check("drain A1", 64'(inst_Ops_1.ops.op0PAddr), 64'd11);
    step();
    check("drain B0", 64'(inst_Ops_0.ops.op0PAddr), 64'd20);
    check("drain B1", 64'(inst_Ops_1.ops.op0PAddr), 64'd21);
    step();
    check("refused pair absent", 64'(enq_req_0), 64'd0);
    iq_ready = 1'b0;

    // Wakeup of a stored entry and of an entry in its write cycle.
    offer(1, 0, mk(12, 13), '0); step(); idle_in();
    check("wake before", 64'(inst_Ops_0.rdys.prs1_rdy), 64'd0);
    wake_Info.wen_2 = 1'b1; wake_Info.wb_num2_i = 6'd12;
    offer(1, 0, mk(12, 17), '0); #1;
    check("wake comb merge", 64'(inst_Ops_0.rdys.prs1_rdy), 64'd1);
    step(); idle_in(); wake_Info = '0; #1;
    check("wake stored prs1", 64'(inst_Ops_0.rdys.prs1_rdy), 64'd1);
    check("wake stored prs2", 64'(inst_Ops_0.rdys.prs2_rdy), 64'd0);
    check("wake write prs1", 64'(inst_Ops_1.rdys.prs1_rdy), 64'd1);
    check("wake write prs2", 64'(inst_Ops_1.rdys.prs2_rdy), 64'd0);
    iq_ready = 1'b1; step(); iq_ready = 1'b0;

    // Slot 1 only.
    offer(0, 1, '0, mk(40, 41)); step(); idle_in();
    iq_ready = 1'b1; #1;
    check("slot1 enq_req_0", 64'(enq_req_0), 64'd1);
    check("slot1 enq_req_1", 64'(enq_req_1), 64'd0);
    check("slot1 head", 64'(inst_Ops_0.ops.op0PAddr), 64'd40);
    step(); iq_ready = 1'b0;

    // Pointer wrap with simultaneous push and pop (head reaches 3, count 3).
    offer(1, 1, mk(50, 1), mk(51, 1)); step();
    offer(1, 1, mk(52, 1), mk(53, 1)); iq_ready = 1'b1; step();
    check("wrap B head", 64'(inst_Ops_0.ops.op0PAddr), 64'd52);
    check("wrap B head+1", 64'(inst_Ops_1.ops.op0PAddr), 64'd53);
    offer(1, 0, mk(54, 1), '0); iq_ready = 1'b0; step();
    check("count3 in_ready", 64'(in_ready), 64'd0);
    offer(1, 1, mk(60, 1), mk(61, 1)); iq_ready = 1'b1; step();
    check("wrap D head", 64'(inst_Ops_0.ops.op0PAddr), 64'd54);
    check("wrap D enq_req_1", 64'(enq_req_1), 64'd0);
    check("wrap D in_ready", 64'(in_ready), 64'd1);
    step();
    check("wrap E head", 64'(inst_Ops_0.ops.op0PAddr), 64'd60);
    check("wrap E head+1", 64'(inst_Ops_1.ops.op0PAddr), 64'd61);
    offer(1, 1, mk(62, 1), mk(63, 1)); step(); idle_in();
    check("wrap F head", 64'(inst_Ops_0.ops.op0PAddr), 64'd62);
    check("wrap F head+1", 64'(inst_Ops_1.ops.op0PAddr), 64'd63);
    step(); iq_ready = 1'b0;

    // Flush at count 3 with incoming uops.
    offer(1, 1, mk(44, 1), mk(45, 1)); step();
    offer(1, 0, mk(46, 1), '0); step();
    flush = 1'b1; offer(1, 1, mk(33, 1), mk(34, 1)); step();
    flush = 1'b0; idle_in();
    check("flush in_ready", 64'(in_ready), 64'd1);
    iq_ready = 1'b1; #1;
    check("flush enq_req_0", 64'(enq_req_0), 64'd0);
    check("flush enq_req_1", 64'(enq_req_1), 64'd0);
    iq_ready = 1'b0;
    offer(1, 1, mk(9, 1), mk(3, 1)); step(); idle_in();
    check("post flush head", 64'(inst_Ops_0.ops.op0PAddr), 64'd9);
    check("post flush head+1", 64'(inst_Ops_1.ops.op0PAddr), 64'd3);
    iq_ready = 1'b1; step(); iq_ready = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
